// File: rtl/sequenciador_exibicao_pkg.sv
// Shared definitions for the playback sequencer: state codes (also consumed by
// the state display decoder) and default LED timing.
package sequenciador_exibicao_pkg;

  // 5-bit codes so the display decoder can show them without translation
  typedef enum logic [4:0] {
    OCIOSO  = 5'd0,
    CARREGA = 5'd1,
    ACENDE  = 5'd2,
    APAGA   = 5'd3,
    FIM     = 5'd4
  } estado_t;

  // Default on-time and gap, in clock cycles, at normal speed
  localparam int T_ON_PADRAO  = 500;
  localparam int T_OFF_PADRAO = 250;

endpackage

// File: rtl/sequenciador_exibicao_contador_tempo.sv
// Cycle timer for LED on/off phases: counts up while enabled, clears
// synchronously, and flags when the count equals a limit supplied at run time.
module contador_tempo #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa,
  input  logic             habilita,
  input  logic [WIDTH-1:0] limite,
  output logic             terminal
);

  logic [WIDTH-1:0] contagem;

  // Count register: clear wins over enable
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of block ordering.
    if (!reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita) begin
      contagem <= contagem + WIDTH'(1);
    end
  end

  // Terminal flag compares against the phase length chosen by the caller
  assign terminal = (contagem == limite);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays the stored colour sequence on the LEDs: for each address 0..limite it
// loads the pattern, shows it for t_on cycles, blanks for t_off cycles, and
// finally pulses fim. Abort and reset both return to OCIOSO cleanly.
module sequenciador_exibicao
  import sequenciador_exibicao_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7,
  parameter int T_ON   = T_ON_PADRAO,
  parameter int T_OFF  = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic              nivel,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [4:0]        db_estado
);

  // Timer wide enough for the longer phase at normal speed
  localparam int TIMER_W = $clog2((T_ON > T_OFF) ? T_ON : T_OFF);

  // Terminal counts (t - 1) for both speeds; fast speed halves each phase
  localparam logic [TIMER_W-1:0] ON_NORMAL   = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] ON_RAPIDO   = TIMER_W'((T_ON >> 1) - 1);
  localparam logic [TIMER_W-1:0] OFF_NORMAL  = TIMER_W'(T_OFF - 1);
  localparam logic [TIMER_W-1:0] OFF_RAPIDO  = TIMER_W'((T_OFF >> 1) - 1);

  estado_t             estado, proximo;
  logic [ADDR_W-1:0]   limite_reg;
  logic                nivel_reg;
  logic [TIMER_W-1:0]  limite_tempo;
  logic                tempo_fim;
  logic                tempo_limpa;
  logic                tempo_habilita;
  logic                em_fase;

  assign em_fase = (estado == ACENDE) || (estado == APAGA);

  // Phase length selection from the speed latched at start
  always_comb begin
    if (estado == ACENDE) begin
      limite_tempo = nivel_reg ? ON_RAPIDO : ON_NORMAL;
    end else begin
      limite_tempo = nivel_reg ? OFF_RAPIDO : OFF_NORMAL;
    end
  end

  // Timer runs only inside a phase and restarts at every phase boundary
  always_comb begin
    tempo_habilita = em_fase;
    tempo_limpa    = abortar || !em_fase || tempo_fim;
  end

  contador_tempo #(
    .WIDTH (TIMER_W)
  ) u_contador_tempo (
    .clock    (clock),
    .reset    (reset),
    .limpa    (tempo_limpa),
    .habilita (tempo_habilita),
    .limite   (limite_tempo),
    .terminal (tempo_fim)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    // NOTE: default assignment first so no path leaves proximo unassigned,
    // which would otherwise infer a latch.
    proximo = estado;
    if (abortar) begin
      proximo = OCIOSO;
    end else begin
      case (estado)
        OCIOSO:  if (iniciar) proximo = CARREGA;
        CARREGA: proximo = ACENDE;
        ACENDE:  if (tempo_fim) proximo = APAGA;
        APAGA:   if (tempo_fim) proximo = (mem_endereco == limite_reg) ? FIM : CARREGA;
        FIM:     proximo = OCIOSO;
        default: proximo = OCIOSO;
      endcase
    end
  end

  // Outputs decoded straight from state
  always_comb begin
    ocupado   = (estado != OCIOSO);
    fim       = (estado == FIM);
    db_estado = estado;
  end

  // Address, LED pattern and start-time parameters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_endereco <= '0;
      leds         <= '0;
      limite_reg   <= '0;
      nivel_reg    <= 1'b0;
    end else if (abortar) begin
      mem_endereco <= '0;
      leds         <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          mem_endereco <= '0;
          leds         <= '0;
          if (iniciar) begin
            limite_reg <= limite;
            nivel_reg  <= nivel;
          end
        end
        CARREGA: leds <= mem_dado;
        ACENDE:  if (tempo_fim) leds <= '0;
        APAGA: begin
          leds <= '0;
          if (tempo_fim && (mem_endereco != limite_reg)) begin
            mem_endereco <= mem_endereco + ADDR_W'(1);
          end
        end
        FIM: begin
          mem_endereco <= '0;
          leds         <= '0;
        end
        default: begin
          mem_endereco <= '0;
          leds         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Bench for sequenciador_exibicao: a timeline model builds the expected
// per-cycle view of every output for a playback and compares it cycle by cycle.
module tb_sequenciador_exibicao;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 7;
  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;

  logic              clock;
  logic              reset;
  logic              iniciar;
  logic              abortar;
  logic              nivel;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              fim;
  logic [4:0]        db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem [16];
  logic [31:0]       exp_q [$];

  sequenciador_exibicao #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .nivel        (nivel),
    .limite       (limite),
    .mem_dado     (mem_dado),
    .mem_endereco (mem_endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sequence memory: data for a new address settles within the cycle after it changes
  assign mem_dado = mem[mem_endereco];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // {state code, ocupado, fim, address, leds}
  function automatic logic [31:0] vec(input logic [4:0] st, input bit oc, input bit fm,
                                      input logic [3:0] ad, input logic [6:0] ld);
    return {14'b0, st, oc, fm, ad, ld};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {14'b0, db_estado, ocupado, fim, mem_endereco, leds};
  endfunction

  // Expected timeline for one playback, starting with the cycle after the sampling edge
  task automatic build_trace(input int lim, input bit niv);
    int t_on, t_off;
    t_on  = niv ? T_ON / 2 : T_ON;
    t_off = niv ? T_OFF / 2 : T_OFF;
    exp_q.delete();
    for (int k = 0; k <= lim; k++) begin
      exp_q.push_back(vec(5'd1, 1'b1, 1'b0, 4'(k), 7'd0));
      for (int c = 0; c < t_on; c++) exp_q.push_back(vec(5'd2, 1'b1, 1'b0, 4'(k), mem[k]));
      for (int c = 0; c < t_off; c++) exp_q.push_back(vec(5'd3, 1'b1, 1'b0, 4'(k), 7'd0));
    end
    exp_q.push_back(vec(5'd4, 1'b1, 1'b1, 4'(lim), 7'd0));
    exp_q.push_back(32'd0);
  endtask

  // One playback; optional mid-run input noise, abort at cycle abort_idx, or reset at reset_idx
  task automatic run_playback(input int lim, input bit niv, input bit disturb,
                              input int abort_idx, input int reset_idx, input string tag);
    build_trace(lim, niv);
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'(lim);
    nivel   = niv;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      check(tag, obs_vec(), exp_q[i]);
      if (i == abort_idx) begin
        abortar = 1'b1;
        iniciar = 1'b1;
        @(negedge clock);
        check({tag, "_abort"}, obs_vec(), 32'd0);
        // abort and start together while idle: abort must win
        @(negedge clock);
        check({tag, "_abort_idle"}, obs_vec(), 32'd0);
        abortar = 1'b0;
        iniciar = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check({tag, "_idle"}, obs_vec(), 32'd0);
        end
        return;
      end
      if (i == reset_idx) begin
        #1 reset = 1'b0;
        #1 check({tag, "_rst_async"}, obs_vec(), 32'd0);
        @(negedge clock);
        check({tag, "_rst_hold"}, obs_vec(), 32'd0);
        iniciar = 1'b0;
        reset   = 1'b1;
        return;
      end
      if (disturb && i < exp_q.size() - 1) begin
        iniciar = 1'($urandom);
        limite  = 4'($urandom);
        nivel   = 1'($urandom);
      end else begin
        iniciar = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 7'(1 << (k % 7));
    reset   = 1'b0;
    iniciar = 1'b0;
    abortar = 1'b0;
    nivel   = 1'b0;
    limite  = '0;
    repeat (2) @(negedge clock);
    check("reset", obs_vec(), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle", obs_vec(), 32'd0);

    run_playback(2, 1'b0, 1'b0, -1, -1, "lim2_normal");
    run_playback(0, 1'b1, 1'b0, -1, -1, "lim0_fast");
    run_playback(15, 1'b0, 1'b0, -1, -1, "lim15_all");
    run_playback(3, 1'b0, 1'b1, -1, -1, "noise_midrun");
    // second element's ACENDE starts at cycle 8; its third cycle is 10
    run_playback(4, 1'b0, 1'b0, 10, -1, "abort");
    run_playback(1, 1'b0, 1'b0, -1, -1, "after_abort");
    // second element's first APAGA cycle is 12
    run_playback(3, 1'b0, 1'b0, -1, 12, "reset_mid");
    run_playback(2, 1'b1, 1'b0, -1, -1, "after_reset");
    repeat (8) run_playback(int'($urandom_range(0, 15)), 1'($urandom), 1'b1, -1, -1, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
